conv_ff_bank: RTL and testbench
===============================

Name: conv_ff_bank

Overview:
WIDTH-bit flip-flop bank whose per-bit next-state rule is selected at run time from four flip-flop types: D, T, JK and SR.
The active type is held in an internal mode register loaded through a write strobe.
The bank also reports which bits changed on the last update and keeps a sticky flag for illegal SR input combinations.
It is the general-purpose storage primitive for the flip-flop conversion library and replaces the separate fixed-type D and JK cells.

Parameters:
WIDTH, 8, number of flip-flops in the bank (>=1)
RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset
SR_ILLEGAL_POLICY, 0, SR-mode response to S=R=1: 0 = hold bit, 1 = toggle bit

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  update enable; q holds when low
mode_we  input  1  load mode_in into mode register
mode_in  input  2  new mode: 00 D, 01 T, 10 JK, 11 SR
a  input  WIDTH  per-bit D / T / J / S input, depending on mode
b  input  WIDTH  per-bit K / R input; ignored in D and T modes
mode  output  2  current mode register value
q  output  WIDTH  flip-flop outputs
q_n  output  WIDTH  always equal to ~q (registered alongside q, never a different value)
changed  output  WIDTH  bits of q that changed at the most recent edge
sr_err  output  1  sticky: an SR-mode update saw a=b=1 on any bit
sr_err_clr  input  1  clears sr_err

Behaviour:
- Reset is synchronous, active-high, and has priority over every other input. On the edge it is sampled:
  - q = RST_VAL, q_n = ~RST_VAL
  - mode = 2'b00 (D)
  - changed = 0
  - sr_err = 0
- Mode register:
  - On an edge with mode_we=1, mode takes mode_in.
  - The q update at that same edge uses the OLD mode; the new mode governs from the next edge.
  - mode_we is honoured regardless of en.
- q update on an edge with en=1 and rst=0, per bit i, with the current mode:
  - D: q[i] <= a[i]
  - T: q[i] <= q[i] ^ a[i]
  - JK (a=J, b=K): 00 hold, 01 clear, 10 set, 11 toggle
  - SR (a=S, b=R): 00 hold, 01 clear, 10 set, 11 per SR_ILLEGAL_POLICY (hold or toggle)
- With en=0: q and q_n hold.
- Latency: q reflects inputs one edge after sampling. No combinational path from a, b or en to q.
- changed:
  - Registered every edge: changed <= (en ? q_next ^ q : 0).
  - Cleared to 0 on reset.
  - Therefore valid in the cycle after the update, together with the new q.
- sr_err:
  - Set condition: en=1, mode==SR, and |(a & b).
  - Clear condition: sr_err_clr=1.
  - If set and clear occur on the same edge, set wins (sr_err stays 1).
  - Not set in JK mode, even with a=b=1.
  - Unaffected by mode changes.
- Bits are fully independent; any WIDTH mix of a/b values is legal every cycle.
- Reset mid-operation: pending mode_we and en on the reset edge are discarded.
- No X propagation from b in D or T modes: b is don't-care there and must not affect q, changed or sr_err.

Test Plan:
All scenarios use WIDTH=4, RST_VAL=4'b0101, SR_ILLEGAL_POLICY=0 unless noted.

1. Reset, then D mode:
   - Stimulus: rst pulse, then en=1, a=4'b1100 for one edge.
   - Required: after reset q=0101, q_n=1010, mode=00. After the edge q=1100, and the next cycle shows changed=1001.
2. T mode with hold:
   - Stimulus: mode_we=1 with mode_in=01 on one edge with en=1, a=1111; then en=1, a=0011; then en=0, a=1111.
   - Required: first edge updates as D (q=1111) because the old mode applies. Second edge gives q=1100. Third edge holds q=1100 with changed=0000.
3. JK mode:
   - Stimulus: mode=10, q=1100; a=4'b1010 (J), b=4'b0110 (K), en=1.
   - Required: per bit J/K = bit3 10, bit2 01, bit1 11, bit0 00 → q=1010, changed=0110, sr_err stays 0.
4. SR illegal with both policies:
   - Stimulus: mode=11, q=0011; a=1001, b=1010.
   - Required with policy 0: q=0001 and sr_err=1 next cycle.
   - Stimulus: repeat with SR_ILLEGAL_POLICY=1.
   - Required with policy 1: q=1001, sr_err=1.
5. sr_err priority:
   - Stimulus: sr_err_clr=1 on the same edge as a new illegal SR input; then sr_err_clr=1 alone.
   - Required: sr_err stays 1 after the first edge, then reads 0 after the second.
6. Reset mid-operation:
   - Stimulus: in SR mode with sr_err=1 and q=1111, assert rst together with mode_we=1, mode_in=10, en=1.
   - Required: q=0101, mode=00, sr_err=0, changed=0000.

Source files
------------

// File: rtl/conv_ff_bank.sv
// Purpose : WIDTH-bit flip-flop bank; per-bit next state follows a run-time selectable D/T/JK/SR rule.
// Latency : q, q_n, changed and sr_err update one clk edge after their inputs are sampled.
// Backpres: none; en=0 holds q, and every other input is accepted on every edge.
//
// Ports:
//   clk, rst           clock (rising edge) and synchronous active-high reset (highest priority)
//   en                 update enable for q/q_n; changed reads 0 after an edge with en=0
//   mode_we, mode_in   load the mode register (00 D, 01 T, 10 JK, 11 SR); takes effect next edge
//   a, b               per-bit D/T/J/S and K/R inputs (b is ignored in D and T modes)
//   mode               current mode register
//   q, q_n             flip-flop outputs and their complement
//   changed            bits of q that flipped at the most recent edge
//   sr_err, sr_err_clr sticky flag for S=R=1 seen in SR mode, and its clear (set wins)
module conv_ff_bank #(
    parameter int               WIDTH             = 8,
    parameter logic [WIDTH-1:0] RST_VAL           = {WIDTH{1'b0}},
    parameter int               SR_ILLEGAL_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode_we,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sr_err_clr,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] changed,
    output logic             sr_err
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } ff_mode_e;

    // Mask applied to q on S=R=1 bits: all-ones toggles them, all-zeros holds them.
    localparam logic [WIDTH-1:0] SR_ILL_MASK = (SR_ILLEGAL_POLICY != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    ff_mode_e         mode_r;
    logic [WIDTH-1:0] q_next;
    logic             sr_err_set;

    // Next-state rule for the whole bank. b is only consulted in the JK and SR
    // branches so that an undriven b cannot leak into q in D or T mode.
    always_comb begin
        q_next = q;
        case (mode_r)
            MODE_D:  q_next = a;
            MODE_T:  q_next = q ^ a;
            // Characteristic equation Q+ = J~Q | ~K Q covers hold/clear/set/toggle.
            MODE_JK: q_next = (a & ~q) | (~b & q);
            // Set, hold, and the S=R=1 case resolved by SR_ILL_MASK; clear is the residue.
            MODE_SR: q_next = (a & ~b) | (~a & ~b & q) | (a & b & (q ^ SR_ILL_MASK));
            default: q_next = q;
        endcase
    end

    assign sr_err_set = en && (mode_r == MODE_SR) && (|(a & b));

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RST_VAL;
            q_n     <= ~RST_VAL;
            mode_r  <= MODE_D;
            changed <= '0;
            sr_err  <= 1'b0;
        end else begin
            // The q update above uses mode_r as it stood before this edge.
            if (mode_we) begin
                mode_r <= ff_mode_e'(mode_in);
            end
            if (en) begin
                q       <= q_next;
                q_n     <= ~q_next;
                changed <= q_next ^ q;
            end else begin
                changed <= '0;
            end
            // Set takes priority over clear on the same edge.
            if (sr_err_set) begin
                sr_err <= 1'b1;
            end else if (sr_err_clr) begin
                sr_err <= 1'b0;
            end
        end
    end

    assign mode = mode_r;

endmodule

// File: tb/tb_conv_ff_bank.sv
// Purpose : directed bench for conv_ff_bank; one instance per SR illegal-input policy, shared stimulus.
// Latency : expected values queued when a step is driven, popped and compared #1 after the following edge.
// Backpres: not applicable; the bench drives one step per clock.
module tb_conv_ff_bank;

    localparam int         W   = 4;
    localparam logic [3:0] RSV = 4'b0101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode_we = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic [3:0] a = 4'b0000;
    logic [3:0] b = 4'b0000;
    logic       sr_err_clr = 1'b0;

    logic [1:0] mode0, mode1;
    logic [3:0] q0, q1, qn0, qn1, ch0, ch1;
    logic       err0, err1;

    always #5 clk = ~clk;

    conv_ff_bank #(.WIDTH(W), .RST_VAL(RSV), .SR_ILLEGAL_POLICY(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode_we(mode_we), .mode_in(mode_in),
        .a(a), .b(b), .sr_err_clr(sr_err_clr),
        .mode(mode0), .q(q0), .q_n(qn0), .changed(ch0), .sr_err(err0)
    );

    conv_ff_bank #(.WIDTH(W), .RST_VAL(RSV), .SR_ILLEGAL_POLICY(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode_we(mode_we), .mode_in(mode_in),
        .a(a), .b(b), .sr_err_clr(sr_err_clr),
        .mode(mode1), .q(q1), .q_n(qn1), .changed(ch1), .sr_err(err1)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] q0;
        logic [3:0] ch0;
        logic       err0;
        logic [3:0] q1;
        logic [3:0] ch1;
        logic       err1;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference state of both banks.
    logic [1:0] m_mode = 2'b00;
    logic [3:0] m_q0 = RSV;
    logic [3:0] m_q1 = RSV;
    logic       m_err0 = 1'b0;
    logic       m_err1 = 1'b0;

    // Bit-by-bit truth-table reference for one update with en=1.
    function automatic logic [3:0] ref_next(input logic [1:0] md, input logic [3:0] qc,
                                            input logic [3:0] av, input logic [3:0] bv,
                                            input bit pol_toggle);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            if (md == 2'b00) begin
                n[i] = av[i];
            end else if (md == 2'b01) begin
                n[i] = av[i] ? ~qc[i] : qc[i];
            end else begin
                case ({av[i], bv[i]})
                    2'b00:   n[i] = qc[i];
                    2'b01:   n[i] = 1'b0;
                    2'b10:   n[i] = 1'b1;
                    default: n[i] = (md == 2'b10 || pol_toggle) ? ~qc[i] : qc[i];
                endcase
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic we, input logic [1:0] mi,
                        input logic [3:0] av, input logic [3:0] bv, input logic clr);
        exp_t x;
        exp_t got;
        logic s;
        @(negedge clk);
        rst = r; en = e; mode_we = we; mode_in = mi; a = av; b = bv; sr_err_clr = clr;
        if (r) begin
            x = '{mode: 2'b00, q0: RSV, ch0: 4'b0000, err0: 1'b0,
                  q1: RSV, ch1: 4'b0000, err1: 1'b0};
        end else begin
            s = e && (m_mode == 2'b11) && (|(av & bv));
            x.mode = we ? mi : m_mode;
            x.q0   = e ? ref_next(m_mode, m_q0, av, bv, 1'b0) : m_q0;
            x.q1   = e ? ref_next(m_mode, m_q1, av, bv, 1'b1) : m_q1;
            x.ch0  = x.q0 ^ m_q0;
            x.ch1  = x.q1 ^ m_q1;
            x.err0 = s | (m_err0 & ~clr);
            x.err1 = s | (m_err1 & ~clr);
        end
        m_mode = x.mode; m_q0 = x.q0; m_q1 = x.q1; m_err0 = x.err0; m_err1 = x.err1;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("mode0", {2'b00, mode0}, {2'b00, got.mode});
        chk("mode1", {2'b00, mode1}, {2'b00, got.mode});
        chk("q0", q0, got.q0);
        chk("q_n0", qn0, ~got.q0);
        chk("changed0", ch0, got.ch0);
        chk("sr_err0", {3'b000, err0}, {3'b000, got.err0});
        chk("q1", q1, got.q1);
        chk("q_n1", qn1, ~got.q1);
        chk("changed1", ch1, got.ch1);
        chk("sr_err1", {3'b000, err1}, {3'b000, got.err1});
    endtask

    initial begin
        // Reset state.
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
        chk("rst_q", q0, 4'b0101);
        chk("rst_qn", qn0, 4'b1010);
        // D mode, b undriven.
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b1100, 4'bxxxx, 1'b0);
        chk("d_q", q0, 4'b1100);
        chk("d_changed", ch0, 4'b1001);
        // Mode write to T on an update edge: this edge still behaves as D.
        step(1'b0, 1'b1, 1'b1, 2'b01, 4'b1111, 4'bxxxx, 1'b0);
        chk("old_mode_q", q0, 4'b1111);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b0011, 4'bxxxx, 1'b0);
        chk("t_q", q0, 4'b1100);
        // en low: hold, changed clears.
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'b1111, 4'bxxxx, 1'b0);
        chk("hold_q", q0, 4'b1100);
        chk("hold_changed", ch0, 4'b0000);
        // JK mode, mode written with en low.
        step(1'b0, 1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b1010, 4'b0110, 1'b0);
        chk("jk_q", q0, 4'b1010);
        chk("jk_changed", ch0, 4'b0110);
        chk("jk_no_err", {3'b000, err0}, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b0011, 4'b1100, 1'b0);
        chk("jk_q2", q0, 4'b0011);
        // SR mode, illegal combination on bit 3 under both policies.
        step(1'b0, 1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b1001, 4'b1010, 1'b0);
        chk("sr_hold_q", q0, 4'b0001);
        chk("sr_toggle_q", q1, 4'b1001);
        chk("sr_err_set", {3'b000, err0}, 4'b0001);
        // Set and clear on the same edge: set wins.
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b1000, 4'b1000, 1'b1);
        chk("set_wins", {3'b000, err1}, 4'b0001);
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1);
        chk("clr_alone", {3'b000, err0}, 4'b0000);
        // Build sr_err=1 and q=1111 in SR mode.
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b1111, 4'b0000, 1'b0);
        chk("pre_rst_q", q1, 4'b1111);
        // Reset with pending mode write and enable: both discarded.
        step(1'b1, 1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b0);
        chk("mid_rst_q", q0, 4'b0101);
        chk("mid_rst_mode", {2'b00, mode0}, 4'b0000);
        // After reset the bank is back in D mode.
        step(1'b0, 1'b1, 1'b0, 2'b00, 4'b0110, 4'bxxxx, 1'b0);
        chk("post_rst_d", q1, 4'b0110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
